// File: rtl/maze_wall_scanner.sv
// maze_wall_scanner
//   Multi-cycle wall checker for a sprite bounding box. A start pulse latches
//   the box (inclusive pixel coordinates) and a move direction. The scanner
//   then walks the overlapped cell rows, one per clock, and reports whether
//   any wall bit of the selected direction lies under the box.
//
// Ports
//   Clk, Reset        clock, synchronous active-high reset
//   start             request pulse, accepted only in IDLE and not during done
//   dir               0=up 1=down 2=left 3=right, latched at start
//   top/bottom/left/right  inclusive sprite box in pixels, latched at start
//   *_constraint      per-cell wall bits [row][col], held stable while busy
//   busy              scan in progress
//   done              one-cycle completion pulse
//   deny, oob         move blocked / box past maze edge, held until next start
//   hit_row, hit_col  first blocking cell (lowest column of first hit row)
module maze_wall_scanner #(
    parameter int SIZE_Y  = 20,
    parameter int SIZE_X  = 40,
    parameter int CELL_PX = 16,
    parameter int COORD_W = 10
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        start,
    input  logic [1:0]                  dir,
    input  logic [COORD_W-1:0]          top,
    input  logic [COORD_W-1:0]          bottom,
    input  logic [COORD_W-1:0]          left,
    input  logic [COORD_W-1:0]          right,
    input  logic [0:SIZE_X-1]           up_constraint    [SIZE_Y-1:0],
    input  logic [0:SIZE_X-1]           down_constraint  [SIZE_Y-1:0],
    input  logic [0:SIZE_X-1]           left_constraint  [SIZE_Y-1:0],
    input  logic [0:SIZE_X-1]           right_constraint [SIZE_Y-1:0],
    output logic                        busy,
    output logic                        done,
    output logic                        deny,
    output logic                        oob,
    output logic [$clog2(SIZE_Y)-1:0]   hit_row,
    output logic [$clog2(SIZE_X)-1:0]   hit_col
);

    localparam int RW = $clog2(SIZE_Y);
    localparam int CW = $clog2(SIZE_X);
    localparam int S  = $clog2(CELL_PX);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t          state, state_nxt;
    logic [1:0]      dir_q, dir_nxt;
    logic [RW-1:0]   row_q, row_nxt;
    logic [RW-1:0]   row_hi_q, row_hi_nxt;
    logic [CW-1:0]   col_lo_q, col_lo_nxt;
    logic [CW-1:0]   col_hi_q, col_hi_nxt;
    logic            fin_hold, fin_hold_nxt;
    logic            done_nxt, deny_nxt, oob_nxt;
    logic [RW-1:0]   hit_row_nxt;
    logic [CW-1:0]   hit_col_nxt;

    logic [COORD_W-1:0] row_lo_c, row_hi_c, col_lo_c, col_hi_c;
    logic [0:SIZE_X-1]  sel_row;
    logic [SIZE_X-1:0]  hits;
    logic [CW-1:0]      first_col;

    assign row_lo_c = top    >> S;
    assign row_hi_c = bottom >> S;
    assign col_lo_c = left   >> S;
    assign col_hi_c = right  >> S;

    assign busy = (state != IDLE);

    // Row under the pointer for the latched direction, masked to the box
    // columns; first_col resolves to the lowest blocking column.
    always_comb begin
        sel_row   = '0;
        hits      = '0;
        first_col = '0;
        case (dir_q)
            2'd0:    sel_row = up_constraint[row_q];
            2'd1:    sel_row = down_constraint[row_q];
            2'd2:    sel_row = left_constraint[row_q];
            default: sel_row = right_constraint[row_q];
        endcase
        for (int unsigned x = 0; x < SIZE_X; x++) begin
            hits[x] = sel_row[x] && (CW'(x) >= col_lo_q) && (CW'(x) <= col_hi_q);
        end
        for (int unsigned x = SIZE_X; x > 0; x--) begin
            if (hits[x-1]) first_col = CW'(x-1);
        end
    end

    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir_q;
        row_nxt      = row_q;
        row_hi_nxt   = row_hi_q;
        col_lo_nxt   = col_lo_q;
        col_hi_nxt   = col_hi_q;
        fin_hold_nxt = fin_hold;
        done_nxt     = 1'b0;
        deny_nxt     = deny;
        oob_nxt      = oob;
        hit_row_nxt  = hit_row;
        hit_col_nxt  = hit_col;

        case (state)
            IDLE: begin
                // A start coinciding with the done pulse is dropped on purpose.
                if (start && !done) begin
                    dir_nxt     = dir;
                    row_nxt     = RW'(row_lo_c);
                    row_hi_nxt  = RW'(row_hi_c);
                    col_lo_nxt  = CW'(col_lo_c);
                    col_hi_nxt  = CW'(col_hi_c);
                    deny_nxt    = 1'b0;
                    oob_nxt     = 1'b0;
                    hit_row_nxt = '0;
                    hit_col_nxt = '0;
                    if ((left > right) || (top > bottom)) begin
                        state_nxt    = FIN;
                        fin_hold_nxt = 1'b1;
                    end else if ((row_hi_c >= COORD_W'(SIZE_Y)) ||
                                 (col_hi_c >= COORD_W'(SIZE_X))) begin
                        deny_nxt     = 1'b1;
                        oob_nxt      = 1'b1;
                        state_nxt    = FIN;
                        fin_hold_nxt = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (|hits) begin
                    deny_nxt    = 1'b1;
                    hit_row_nxt = row_q;
                    hit_col_nxt = first_col;
                    state_nxt   = FIN;
                end else if (row_q == row_hi_q) begin
                    state_nxt = FIN;
                end else begin
                    row_nxt = row_q + 1'b1;
                end
            end
            FIN: begin
                // Early-decided requests spend one extra cycle here so their
                // done lands two edges after start, like a one-row scan.
                if (fin_hold) begin
                    fin_hold_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            dir_q    <= '0;
            row_q    <= '0;
            row_hi_q <= '0;
            col_lo_q <= '0;
            col_hi_q <= '0;
            fin_hold <= 1'b0;
            done     <= 1'b0;
            deny     <= 1'b0;
            oob      <= 1'b0;
            hit_row  <= '0;
            hit_col  <= '0;
        end else begin
            state    <= state_nxt;
            dir_q    <= dir_nxt;
            row_q    <= row_nxt;
            row_hi_q <= row_hi_nxt;
            col_lo_q <= col_lo_nxt;
            col_hi_q <= col_hi_nxt;
            fin_hold <= fin_hold_nxt;
            done     <= done_nxt;
            deny     <= deny_nxt;
            oob      <= oob_nxt;
            hit_row  <= hit_row_nxt;
            hit_col  <= hit_col_nxt;
        end
    end

endmodule

// File: tb/tb_maze_wall_scanner.sv
// tb_maze_wall_scanner
//   Self-checking bench for maze_wall_scanner with default parameters.
//   Table-driven requests; expected results are queued at start and
//   compared when done appears.
module tb_maze_wall_scanner;

    localparam int SIZE_Y  = 20;
    localparam int SIZE_X  = 40;
    localparam int COORD_W = 10;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         dir = '0;
    logic [COORD_W-1:0] top = '0, bottom = '0, left_px = '0, right_px = '0;
    logic [0:SIZE_X-1]  up_c    [SIZE_Y-1:0];
    logic [0:SIZE_X-1]  down_c  [SIZE_Y-1:0];
    logic [0:SIZE_X-1]  left_c  [SIZE_Y-1:0];
    logic [0:SIZE_X-1]  right_c [SIZE_Y-1:0];
    logic               busy, done, deny, oob;
    logic [4:0]         hit_row;
    logic [5:0]         hit_col;

    maze_wall_scanner #(
        .SIZE_Y(SIZE_Y), .SIZE_X(SIZE_X), .CELL_PX(16), .COORD_W(COORD_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .dir(dir),
        .top(top), .bottom(bottom), .left(left_px), .right(right_px),
        .up_constraint(up_c), .down_constraint(down_c),
        .left_constraint(left_c), .right_constraint(right_c),
        .busy(busy), .done(done), .deny(deny), .oob(oob),
        .hit_row(hit_row), .hit_col(hit_col)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int l, r, t, b, d;
        int wdir;
        int wv0, wr0, wc0, wv1, wr1, wc1;
        int deny, oob, hr, hc, edges;
    } vec_t;

    vec_t vecs [12];
    vec_t sb [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic clear_walls();
        for (int y = 0; y < SIZE_Y; y++) begin
            up_c[y] = '0; down_c[y] = '0; left_c[y] = '0; right_c[y] = '0;
        end
    endtask

    task automatic set_wall(input int d, input int r, input int c);
        case (d)
            0: up_c[r][c]    = 1'b1;
            1: down_c[r][c]  = 1'b1;
            2: left_c[r][c]  = 1'b1;
            default: right_c[r][c] = 1'b1;
        endcase
    endtask

    task automatic load_vec(input vec_t v);
        clear_walls();
        if (v.wv0 != 0) set_wall(v.wdir, v.wr0, v.wc0);
        if (v.wv1 != 0) set_wall(v.wdir, v.wr1, v.wc1);
        left_px = v.l[COORD_W-1:0];
        right_px = v.r[COORD_W-1:0];
        top = v.t[COORD_W-1:0];
        bottom = v.b[COORD_W-1:0];
        dir = v.d[1:0];
    endtask

    // Called at a negedge. pulse_at > 0 re-issues start (with an inverted
    // box) after that many edges, which must be ignored.
    task automatic run_vec(input int i, input int pulse_at);
        vec_t e;
        int edges;
        bit got;
        load_vec(vecs[i]);
        sb.push_back(vecs[i]);
        start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
        @(negedge Clk);
        check("busy_after_start", i, int'(busy), 1);
        edges = 0;
        got = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == pulse_at + 1 && pulse_at > 0) begin
                left_px = 10'd50; right_px = 10'd40; start = 1'b1;
            end
            @(posedge Clk); #1 start = 1'b0;
            @(negedge Clk);
            if (k == pulse_at + 1 && pulse_at > 0) check("busy_mid_start", i, int'(busy), 1);
            if (done) begin
                edges = k;
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check("done_timeout", i, 0, 1);
        end else begin
            check("latency", i, edges, e.edges);
            check("deny", i, int'(deny), e.deny);
            check("oob", i, int'(oob), e.oob);
            check("hit_row", i, int'(hit_row), e.hr);
            check("hit_col", i, int'(hit_col), e.hc);
            check("busy_at_done", i, int'(busy), 0);
            // start during the done cycle must be dropped
            load_vec(vecs[0]);
            start = 1'b1;
            @(posedge Clk); #1 start = 1'b0;
            @(negedge Clk);
            check("start_in_done_ignored", i, int'(busy), 0);
            check("done_one_cycle", i, int'(done), 0);
            check("deny_held", i, int'(deny), e.deny);
            check("hit_col_held", i, int'(hit_col), e.hc);
        end
    endtask

    initial begin
        bit saw_done;
        //          l    r    t    b   d  wd v0 r0 c0 v1 r1 c1 deny oob hr hc edges
        vecs[0]  = '{20,  35,  40,  55, 0, 0, 1, 3, 2, 0, 0, 0, 1, 0, 3, 2, 3};
        vecs[1]  = '{20,  35,  40,  55, 2, 0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 3};
        vecs[2]  = '{630, 645, 40,  55, 1, 1, 1, 3, 2, 0, 0, 0, 1, 1, 0, 0, 2};
        vecs[3]  = '{50,  40,  40,  55, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 2};
        vecs[4]  = '{20,  35,  0,  319, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 2};
        vecs[5]  = '{20,  35,  0,  319, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 21};
        vecs[6]  = '{100, 100, 100, 100, 3, 3, 1, 6, 6, 0, 0, 0, 1, 0, 6, 6, 2};
        vecs[7]  = '{31,  32,  15,  16, 3, 3, 1, 1, 2, 0, 0, 0, 1, 0, 1, 2, 3};
        vecs[8]  = '{0,   639, 304, 319, 0, 0, 1, 19, 30, 1, 19, 5, 1, 0, 19, 5, 2};
        vecs[9]  = '{20,  35,  40,  55, 2, 2, 1, 2, 3, 1, 4, 1, 0, 0, 0, 0, 3};
        vecs[10] = '{20,  35,  310, 320, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2};
        vecs[11] = '{630, 645, 60,  40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};

        clear_walls();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("reset_busy", -1, int'(busy), 0);
        check("reset_done", -1, int'(done), 0);
        check("reset_deny", -1, int'(deny), 0);
        check("reset_oob", -1, int'(oob), 0);
        check("reset_hit_row", -1, int'(hit_row), 0);
        check("reset_hit_col", -1, int'(hit_col), 0);
        @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, 0);
            @(negedge Clk);
        end

        // start pulsed while a full 20-row scan is in flight
        run_vec(5, 5);
        @(negedge Clk);

        // reset during SCAN abandons the request without a done pulse
        run_vec(0, 0);
        @(negedge Clk);
        load_vec(vecs[5]);
        start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("busy_before_reset", 5, int'(busy), 1);
        Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        check("busy_after_reset", 5, int'(busy), 0);
        check("deny_after_reset", 5, int'(deny), 0);
        check("done_after_reset", 5, int'(done), 0);
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge Clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("no_done_after_reset", 5, int'(saw_done), 0);

        // a fresh request after reset reproduces the first scenario
        run_vec(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
